// File: rtl/ntt_coeff_buffer.sv
// ============================================================================
// ntt_coeff_buffer: two-bank coefficient store between a stream and an NTT wrapper
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module ntt_coeff_buffer #(
  parameter int LOGQ = 64,
  parameter int LOGN = 12,
  parameter int AW   = (LOGN < 9) ? 10 : LOGN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LOGQ-1:0] in_data,
  output logic            ntt_start,
  input  logic [AW-1:0]   ntt_read_address,
  input  logic [AW-1:0]   ntt_write_address,
  input  logic            ntt_wea,
  output logic [LOGQ-1:0] ntt_data_in_0,
  output logic [LOGQ-1:0] ntt_data_in_1,
  input  logic [LOGQ-1:0] ntt_data_out_0,
  input  logic [LOGQ-1:0] ntt_data_out_1,
  input  logic            ntt_finish,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGQ-1:0] out_data,
  output logic            out_last,
  output logic            busy
);

  localparam int HALF = 1 << (LOGN - 1);
  localparam int HW   = LOGN - 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_UNLOAD} state_t;

  state_t          r_state, w_next;
  logic [LOGQ-1:0] r_bank0 [HALF];
  logic [LOGQ-1:0] r_bank1 [HALF];

  logic [LOGN-1:0] r_k;
  logic [LOGN-1:0] r_iss_idx;
  logic            r_iss_done;
  logic            r_pend, r_pend_sel, r_pend_last;
  logic [LOGQ-1:0] r_rd0, r_rd1;
  logic            r_skid_vld, r_skid_last;
  logic [LOGQ-1:0] r_skid;
  logic            r_out_valid, r_out_last;
  logic [LOGQ-1:0] r_out_data;

  logic            w_in_beat, w_pop, w_issue, w_out_load;
  logic [1:0]      w_occ_next;
  logic [HW-1:0]   w_rd_addr, w_wa;
  logic            w_we0, w_we1;
  logic [LOGQ-1:0] w_wd0, w_wd1, w_pend_data;
  logic            w_unused;

  assign w_unused  = ^{ntt_read_address[AW-1:HW], ntt_write_address[AW-1:HW]};

  assign w_in_beat = (r_state == S_LOAD) && in_valid;
  assign w_pop     = r_out_valid && out_ready;

  // Slots held after this edge; a new read may only issue if its data will
  // still find a free slot (output or skid) when it lands next cycle.
  assign w_occ_next = 2'(r_out_valid) + 2'(r_skid_vld) + 2'(r_pend) - 2'(w_pop);
  assign w_issue    = (r_state == S_UNLOAD) && !r_iss_done && (w_occ_next <= 2'd1);
  assign w_out_load = !r_out_valid || w_pop;

  assign w_rd_addr   = (r_state == S_RUN) ? ntt_read_address[HW-1:0] : r_iss_idx[HW-1:0];
  assign w_pend_data = r_pend_sel ? r_rd1 : r_rd0;

  assign w_wa  = (r_state == S_LOAD) ? r_k[HW-1:0] : ntt_write_address[HW-1:0];
  assign w_wd0 = (r_state == S_LOAD) ? in_data : ntt_data_out_0;
  assign w_wd1 = (r_state == S_LOAD) ? in_data : ntt_data_out_1;
  assign w_we0 = (w_in_beat && !r_k[HW]) || ((r_state == S_RUN) && ntt_wea);
  assign w_we1 = (w_in_beat &&  r_k[HW]) || ((r_state == S_RUN) && ntt_wea);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    ntt_start = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (load_start) w_next = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (w_in_beat && (&r_k)) w_next = S_RUN;
      end
      S_RUN: begin
        ntt_start = 1'b1;
        if (ntt_finish) w_next = S_UNLOAD;
      end
      S_UNLOAD: begin
        if (w_pop && r_out_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Storage is deliberately not reset so contents survive across jobs.
  always_ff @(posedge clk) begin
    if (w_we0) r_bank0[w_wa] <= w_wd0;
    if (w_we1) r_bank1[w_wa] <= w_wd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k         <= '0;
      r_rd0       <= '0;
      r_rd1       <= '0;
      r_iss_idx   <= '0;
      r_iss_done  <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_sel  <= 1'b0;
      r_pend_last <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_skid_last <= 1'b0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_rd0 <= r_bank0[w_rd_addr];
      r_rd1 <= r_bank1[w_rd_addr];

      if (r_state == S_IDLE)  r_k <= '0;
      else if (w_in_beat)     r_k <= r_k + 1'b1;

      if (r_state != S_UNLOAD) begin
        r_iss_idx   <= '0;
        r_iss_done  <= 1'b0;
        r_pend      <= 1'b0;
        r_skid_vld  <= 1'b0;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else begin
        r_pend      <= w_issue;
        r_pend_sel  <= r_iss_idx[HW];
        r_pend_last <= &r_iss_idx;
        if (w_issue) begin
          r_iss_idx <= r_iss_idx + 1'b1;
          if (&r_iss_idx) r_iss_done <= 1'b1;
        end
        if (w_out_load) begin
          if (r_skid_vld) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_skid;
            r_out_last  <= r_skid_last;
            r_skid_vld  <= r_pend;
            r_skid      <= w_pend_data;
            r_skid_last <= r_pend_last;
          end else begin
            r_out_valid <= r_pend;
            r_out_data  <= w_pend_data;
            r_out_last  <= r_pend && r_pend_last;
          end
        end else if (r_pend) begin
          r_skid_vld  <= 1'b1;
          r_skid      <= w_pend_data;
          r_skid_last <= r_pend_last;
        end
      end
    end
  end

  assign ntt_data_in_0 = r_rd0;
  assign ntt_data_in_1 = r_rd1;
  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_last      = r_out_last;

endmodule

`default_nettype wire

// File: tb/tb_ntt_coeff_buffer.sv
// ============================================================================
// tb_ntt_coeff_buffer: randomized jobs checked against a 16-entry array model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ntt_coeff_buffer;

  localparam int LOGQ = 64;
  localparam int LOGN = 4;
  localparam int AW   = 10;
  localparam int N    = 16;
  localparam int H    = 8;

  logic            clk, rst, load_start, in_valid, in_ready;
  logic [LOGQ-1:0] in_data;
  logic            ntt_start, ntt_wea, ntt_finish;
  logic [AW-1:0]   ntt_read_address, ntt_write_address;
  logic [LOGQ-1:0] ntt_data_in_0, ntt_data_in_1, ntt_data_out_0, ntt_data_out_1;
  logic            out_valid, out_ready, out_last, busy;
  logic [LOGQ-1:0] out_data;

  logic [LOGQ-1:0] mdl [N];
  int n_cmp = 0;
  int n_err = 0;

  ntt_coeff_buffer #(.LOGQ(LOGQ), .LOGN(LOGN), .AW(AW)) dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ntt_start(ntt_start),
    .ntt_read_address(ntt_read_address), .ntt_write_address(ntt_write_address),
    .ntt_wea(ntt_wea),
    .ntt_data_in_0(ntt_data_in_0), .ntt_data_in_1(ntt_data_in_1),
    .ntt_data_out_0(ntt_data_out_0), .ntt_data_out_1(ntt_data_out_1),
    .ntt_finish(ntt_finish),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic load_job(input bit seq, input bit gap);
    int beats = 0;
    int cyc   = 0;
    logic [63:0] v;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check("in_ready_load", 64'(in_ready), 64'd1);
    check("busy_load", 64'(busy), 64'd1);
    v = seq ? 64'd0 : {$urandom, $urandom};
    while (beats < N && cyc < 200) begin
      in_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = v;
      if (in_valid && in_ready) begin
        mdl[beats] = v;
        beats++;
        v = seq ? 64'(beats) : {$urandom, $urandom};
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("load_beats", 64'(beats), 64'(N));
    check("ntt_start_rise", 64'(ntt_start), 64'd1);
    check("in_ready_after_load", 64'(in_ready), 64'd0);
  endtask

  task automatic run_ntt(input bit plus1, input bit poke);
    int q[$];
    int pra = -1;
    int wait_c = 0;
    logic [63:0] e0 = '0, e1 = '0, ne0, ne1;
    while (!ntt_start && wait_c < 50) begin
      wait_c++;
      @(negedge clk);
    end
    check("ntt_start_wait", 64'(ntt_start), 64'd1);
    for (int i = 0; i < H; i++) begin
      q.push_back(i);
      if (plus1 && i == 3) q.push_back(3);
    end
    for (int s = 0; s <= q.size(); s++) begin
      if (pra >= 0) begin
        check("ntt_rd0", ntt_data_in_0, e0);
        check("ntt_rd1", ntt_data_in_1, e1);
      end
      ne0 = '0;
      ne1 = '0;
      if (s < q.size()) begin
        ntt_read_address = AW'(q[s]);
        ne0 = mdl[q[s]];
        ne1 = mdl[q[s] + H];
      end
      ntt_wea = (pra >= 0);
      if (pra >= 0) begin
        ntt_write_address = AW'(pra);
        ntt_data_out_0    = plus1 ? e0 + 64'd1 : e0;
        ntt_data_out_1    = plus1 ? e1 + 64'd1 : e1;
        mdl[pra]     = ntt_data_out_0;
        mdl[pra + H] = ntt_data_out_1;
      end
      e0  = ne0;
      e1  = ne1;
      pra = (s < q.size()) ? q[s] : -1;
      load_start = poke && (s == 2);
      @(negedge clk);
    end
    load_start = 1'b0;
    ntt_wea    = 1'b0;
    ntt_finish = 1'b1;
    @(negedge clk);
    ntt_finish = 1'b0;
    check("ntt_start_drop", 64'(ntt_start), 64'd0);
  endtask

  task automatic unload_job(input int rmode, input int abort_at);
    int idx = 0;
    int cyc = 0;
    int first = -1;
    bit stalled = 1'b0;
    logic [63:0] held_d = '0;
    logic held_l = 1'b0;
    int pat[4] = '{1, 0, 0, 1};
    while (idx < N && cyc < 300 && !(abort_at > 0 && idx >= abort_at)) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (pat[cyc % 4] != 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (stalled) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", out_data, held_d);
        check("hold_last", 64'(out_last), 64'(held_l));
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (first < 0) first = cyc;
        if (out_ready) begin
          check("out_data", out_data, mdl[idx]);
          check("out_last", 64'(out_last), 64'(idx == N - 1));
          idx++;
        end else begin
          stalled = 1'b1;
          held_d  = mdl[idx];
          held_l  = (idx == N - 1);
        end
      end
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    if (abort_at > 0) begin
      check("abort_words", 64'(idx), 64'(abort_at));
      rst = 1'b0;
      #1;
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_ntt_start", 64'(ntt_start), 64'd0);
      check("abort_out_data", out_data, 64'd0);
      check("abort_rd0", ntt_data_in_0, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("idle_after_abort", 64'(busy), 64'd0);
    end else begin
      check("unload_words", 64'(idx), 64'(N));
      check("busy_after", 64'(busy), 64'd0);
      check("out_valid_after", 64'(out_valid), 64'd0);
      if (rmode == 0) begin
        check("first_latency", 64'(first >= 0 && first <= 2), 64'd1);
        check("burst_cycles", 64'(cyc - first), 64'(N));
      end
    end
  endtask

  task automatic do_job(input bit seq, input bit gap, input bit plus1, input bit poke,
                        input int rmode, input int abort_at);
    load_job(seq, gap);
    run_ntt(plus1, poke);
    unload_job(rmode, abort_at);
  endtask

  initial begin
    rst = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = '0;
    ntt_read_address = '0; ntt_write_address = '0; ntt_wea = 1'b0;
    ntt_data_out_0 = '0; ntt_data_out_1 = '0; ntt_finish = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_ntt_start", 64'(ntt_start), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_rd0", ntt_data_in_0, 64'd0);
    check("rst_rd1", ntt_data_in_1, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    do_job(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    do_job(1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    do_job(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    do_job(1'b0, 1'b0, 1'b0, 1'b1, 2, 0);
    do_job(1'b0, 1'b1, 1'b0, 1'b0, 0, 5);
    do_job(1'b0, 1'b1, 1'b1, 1'b0, 2, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ntt_coeff_buffer.md
NTT_COEFF_BUFFER -- requirements
Module: ntt_coeff_buffer

Interface
REQ-001 Parameter: LOGQ, 64, coefficient width in bits.
REQ-002 Parameter: LOGN, 12, log2 of polynomial length N.
REQ-003 Parameter: AW, (LOGN<9)?10:LOGN, width of the NTT-side address ports.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port: clk  in  1  rising-edge clock.
REQ-006 Port: rst  in  1  asynchronous reset, active-low.
REQ-007 Port: load_start  in  1  single-cycle pulse that starts one load/run/unload job.
REQ-008 Port: in_valid / in_ready  in / out  1 / 1  input coefficient stream handshake.
REQ-009 Port: in_data  in  LOGQ  input coefficient, natural order 0..N-1.
REQ-010 Port: ntt_start  out  1  start level driven to the NTT memory wrapper.
REQ-011 Port: ntt_read_address / ntt_write_address  in  AW / AW  wrapper pair addresses; only bits [LOGN-2:0] are used.
REQ-012 Port: ntt_wea  in  1  wrapper write enable.
REQ-013 Port: ntt_data_in_0 / ntt_data_in_1  out  LOGQ each  coefficients [ra] and [ra+N/2] returned to the wrapper.
REQ-014 Port: ntt_data_out_0 / ntt_data_out_1  in  LOGQ each  wrapper results for [wa] and [wa+N/2].
REQ-015 Port: ntt_finish  in  1  wrapper completion.
REQ-016 Port: out_valid / out_ready  out / in  1 / 1  output stream handshake.
REQ-017 Port: out_data  out  LOGQ  result coefficient, natural order.
REQ-018 Port: out_last  out  1  high with coefficient N-1.
REQ-019 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-020 Storage SHALL be two banks of N/2 x LOGQ: bank0 holds indices 0..N/2-1 and bank1 holds N/2..N-1; each bank has one read port and one write port, is read-first, and has 1-cycle read latency.
REQ-021 The FSM SHALL have the states IDLE, LOAD, RUN, UNLOAD; a load_start pulse in IDLE SHALL move it to LOAD with the index counter at 0; load_start outside IDLE SHALL be ignored.
REQ-022 In LOAD, in_ready SHALL be 1; each in_valid&in_ready beat SHALL write in_data to index k (bank k[LOGN-1], address k[LOGN-2:0]) and increment k; the beat with k=N-1 SHALL move the FSM to RUN.
REQ-023 In RUN, ntt_start SHALL be 1 from the first RUN cycle until ntt_finish is sampled high; ntt_start SHALL be 0 in the following cycle, and the FSM SHALL enter UNLOAD.
REQ-024 In RUN, ntt_data_in_0 and ntt_data_in_1 SHALL present bank0[ra] and bank1[ra] exactly one cycle after ntt_read_address=ra is sampled, and SHALL be registered.
REQ-025 In RUN with ntt_wea=1, ntt_data_out_0 SHALL be written to bank0[wa] and ntt_data_out_1 to bank1[wa] in the same cycle; ntt_wea outside RUN SHALL be ignored.
REQ-026 A read and a write to the same address in the same cycle SHALL return the old data.
REQ-027 In UNLOAD, indices 0..N-1 SHALL be streamed in order through a prefetch/skid stage, so that out_valid stays 1 through a contiguous burst when out_ready=1, giving 1 word per cycle after at most 2 cycles of initial latency.
REQ-028 out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0; no word may be dropped or duplicated.
REQ-029 The transfer of index N-1 (out_last=1) SHALL return the FSM to IDLE in the next cycle.
REQ-030 in_ready SHALL be 0 outside LOAD; out_valid SHALL be 0 outside UNLOAD.
REQ-031 Bank contents SHALL persist across jobs and are not cleared by reset.

Reset
REQ-032 When rst=0, asynchronously: FSM to IDLE; counters 0; in_ready, ntt_start, out_valid, out_last, busy all 0; ntt_data_in_0/1 and out_data 0.
REQ-033 Reset asserted mid-job SHALL abort the job; the next job SHALL need a fresh load_start after rst returns to 1.

Verification
REQ-034 LOGN=4, load 0..15, wrapper model echoes data unchanged (wa=ra, wea one cycle later), out_ready=1 -> out_data 0..15 in 16 consecutive cycles, out_last only on value 15, busy=0 after.
REQ-035 Same flow with out_ready toggling 1,0,0,1 -> the same 16 values in order, out_data stable whenever stalled, no duplicates.
REQ-036 Load with in_valid gapped 50% -> exactly 16 beats accepted; ntt_start rises in the cycle after the 16th beat.
REQ-037 Model writes x+1 to every pair, ra=3 read concurrent with wa=3 write -> the read returns the old value; the final output is input+1 for all 16 indices.
REQ-038 rst=0 pulsed during UNLOAD after 5 words -> out_valid=0 immediately, busy=0; a new job afterwards completes correctly.
REQ-039 load_start pulsed during RUN -> no effect; the job completes normally.
